dmem_bus_ctrl: RTL and testbench



---
 rtl/dmem_bus_pkg.sv | 43 ++++
 rtl/dmem_lane_sel.sv | 63 ++++++
 rtl/dmem_bus_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_pkg.sv
// Shared types and helpers for the data-memory bus controller.
// Build option: DMEM_BYTE_STORE_EN (see dmem_lane_sel) enables STRB lane steering.
package dmem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returned to the core when the memory never acknowledges.
    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

    // Width of the BUS-state timeout counter (TIMEOUT is 1..255).
    localparam int TMO_W = 8;

    // Byte enable for a single byte lane; lane 0 is bits 7:0.
    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        logic [3:0] be;
        case (lane)
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0010;
            2'd2:    be = 4'b0100;
            2'd3:    be = 4'b1000;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Pick one byte lane out of a bus word.
    function automatic logic [7:0] lane_byte(input logic [31:0] data, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            2'd3:    b = data[31:24];
            default: b = data[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_lane_sel.sv
// Byte-lane steering: byte enables and write-lane replication for the
// access being issued, byte extraction/zero-extension for the load result.
// Build option: DMEM_BYTE_STORE_EN makes STRB drive a single lane; without it
// a byte store is issued as a full word store.
module dmem_lane_sel
    import dmem_bus_pkg::*;
(
    input  logic [1:0]  wr_lane,
    input  logic        wr_lsb,
    input  logic        wr_we,
    input  logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data_lane,
    input  logic [1:0]  rd_lane,
    input  logic        rd_lsb,
    input  logic [31:0] rd_data,
    output logic [31:0] rd_data_ext
);

    logic byte_acc_s;

    // Decide whether the issued access is a single-byte access.
    always_comb begin
        byte_acc_s = 1'b0;
`ifdef DMEM_BYTE_STORE_EN
        byte_acc_s = wr_lsb;
`else
        if (wr_we) begin
            byte_acc_s = 1'b0;
        end else begin
            byte_acc_s = wr_lsb;
        end
`endif
    end

    // Byte enables and write data presented on the bus.
    always_comb begin
        wr_be        = 4'hF;
        wr_data_lane = wr_data;
        if (byte_acc_s) begin
            wr_be = lane_onehot(wr_lane);
            if (wr_we) begin
                wr_data_lane = {4{wr_data[7:0]}};
            end else begin
                wr_data_lane = wr_data;
            end
        end else begin
            wr_be        = 4'hF;
            wr_data_lane = wr_data;
        end
    end

    // Load result: whole word, or the addressed byte zero-extended.
    always_comb begin
        rd_data_ext = rd_data;
        if (rd_lsb) begin
            rd_data_ext = {24'd0, lane_byte(rd_data, rd_lane)};
        end else begin
            rd_data_ext = rd_data;
        end
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Multi-cycle data-memory bus controller: registers a core access, holds it
// on a req/ack bus, stalls the core until ack or timeout.
// Build option: DMEM_BYTE_STORE_EN (byte stores steered to one lane).
module dmem_bus_ctrl
    import dmem_bus_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        LSB,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        BusReq,
    output logic        BusWe,
    output logic [29:0] BusAdr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusBe,
    input  logic [31:0] BusRData,
    input  logic        BusAck,
    output logic        BusErr
);

    // Counter value on the last BUS cycle before giving up.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t            state_r;
    state_t            state_s;
    logic [TMO_W-1:0]  count_r;
    logic              lsb_r;
    logic [1:0]        lane_r;
    logic              req_s;
    logic              stall_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_lane_s;
    logic [31:0]       rdata_ext_s;

    assign req_s = MemWrite | MemRead;
    assign Stall = stall_s;

    dmem_lane_sel u_lane_sel (
        .wr_lane      (DataAdr[1:0]),
        .wr_lsb       (LSB),
        .wr_we        (MemWrite),
        .wr_data      (WriteData),
        .wr_be        (be_s),
        .wr_data_lane (wdata_lane_s),
        .rd_lane      (lane_r),
        .rd_lsb       (lsb_r),
        .rd_data      (BusRData),
        .rd_data_ext  (rdata_ext_s)
    );

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_s = BUS;
                end else begin
                    state_s = IDLE;
                end
            end
            BUS: begin
                if (BusAck) begin
                    state_s = DONE;
                end else if (count_r == TMO_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = BUS;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Core stall: asserted from the request cycle until the access completes.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE:    stall_s = req_s;
            BUS:     stall_s = 1'b1;
            DONE:    stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // State register, latched access, bus outputs, timeout and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            count_r  <= '0;
            lsb_r    <= 1'b0;
            lane_r   <= 2'd0;
            BusReq   <= 1'b0;
            BusWe    <= 1'b0;
            BusAdr   <= 30'd0;
            BusWData <= 32'd0;
            BusBe    <= 4'd0;
            ReadData <= 32'd0;
            BusErr   <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        // A write wins when both strobes are present.
                        BusWe    <= MemWrite;
                        BusAdr   <= DataAdr[31:2];
                        BusBe    <= be_s;
                        BusWData <= wdata_lane_s;
                        lsb_r    <= LSB;
                        lane_r   <= DataAdr[1:0];
                        BusReq   <= 1'b1;
                        count_r  <= '0;
                    end else begin
                        BusReq <= 1'b0;
                    end
                end
                BUS: begin
                    if (BusAck) begin
                        BusReq <= 1'b0;
                        if (!BusWe) begin
                            ReadData <= rdata_ext_s;
                        end else begin
                            ReadData <= ReadData;
                        end
                    end else if (count_r == TMO_LAST) begin
                        BusReq   <= 1'b0;
                        BusErr   <= 1'b1;
                        ReadData <= BUS_ERR_DATA;
                    end else begin
                        count_r <= count_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    BusReq <= 1'b0;
                end
                default: begin
                    BusReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: the driver queues the expected result
// of each access, a negedge monitor checks it when the access completes.
module tb_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead, LSB;
    logic [31:0] DataAdr, WriteData, ReadData;
    logic        Stall, BusReq, BusWe;
    logic [29:0] BusAdr;
    logic [31:0] BusWData;
    logic [3:0]  BusBe;
    logic [31:0] BusRData;
    logic        BusAck;
    logic        BusErr;

    int nchecks = 0;
    int nerrs   = 0;

    typedef struct {
        logic [29:0] adr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          bus;
    } exp_t;

    exp_t q[$];

    dmem_bus_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .LSB(LSB), .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData),
        .Stall(Stall), .BusReq(BusReq), .BusWe(BusWe), .BusAdr(BusAdr),
        .BusWData(BusWData), .BusBe(BusBe), .BusRData(BusRData), .BusAck(BusAck),
        .BusErr(BusErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [29:0] adr, input logic we, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] rd,
                                input logic err, input int bus);
        exp_t e;
        e.adr = adr; e.we = we; e.be = be; e.wdata = wdata;
        e.rd = rd; e.err = err; e.bus = bus;
        return e;
    endfunction

    // Monitor state
    int          bus_cnt   = 0;
    int          stall_cnt = 0;
    logic        prev_req  = 1'b0;
    logic        unstable  = 1'b0;
    logic [29:0] cap_adr;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    // Monitor: track bus cycles and stall cycles, check at BusReq release.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            bus_cnt   <= 0;
            stall_cnt <= 0;
            prev_req  <= 1'b0;
            unstable  <= 1'b0;
        end else begin
            if (BusReq) begin
                if (bus_cnt == 0) begin
                    cap_adr <= BusAdr; cap_we <= BusWe; cap_be <= BusBe; cap_wdata <= BusWData;
                end else if (BusAdr !== cap_adr || BusWe !== cap_we ||
                             BusBe !== cap_be || BusWData !== cap_wdata) begin
                    unstable <= 1'b1;
                end
                bus_cnt <= bus_cnt + 1;
            end
            if (Stall) stall_cnt <= stall_cnt + 1;
            if (prev_req && !BusReq) begin
                if (q.size() == 0) begin
                    nchecks++;
                    nerrs++;
                    $display("FAIL unexpected_completion: got completion expected none");
                end else begin
                    e = q.pop_front();
                    chk("bus_adr",      32'(cap_adr),   32'(e.adr));
                    chk("bus_we",       32'(cap_we),    32'(e.we));
                    chk("bus_be",       32'(cap_be),    32'(e.be));
                    chk("bus_wdata",    cap_wdata,      e.wdata);
                    chk("bus_stable",   32'(unstable),  32'd0);
                    chk("bus_cycles",   32'(bus_cnt),   32'(e.bus));
                    chk("stall_cycles", 32'(stall_cnt), 32'(e.bus + 1));
                    chk("stall_done",   32'(Stall),     32'd0);
                    chk("read_data",    ReadData,       e.rd);
                    chk("bus_err",      32'(BusErr),    32'(e.err));
                end
                bus_cnt   <= 0;
                stall_cnt <= 0;
                unstable  <= 1'b0;
            end else if (!Stall && !BusReq) begin
                stall_cnt <= 0;
            end
            prev_req <= BusReq;
        end
    end

    // Issue one access; ack_k = BUS cycle carrying the ack (0 = never ack).
    task automatic access(input logic we, input logic rd, input logic lsb,
                          input logic [31:0] adr, input logic [31:0] wd,
                          input int ack_k, input logic [31:0] brd, input exp_t e);
        int n;
        q.push_back(e);
        MemWrite = we; MemRead = rd; LSB = lsb; DataAdr = adr; WriteData = wd;
        @(posedge clk); #1;
        if (ack_k > 0) begin
            repeat (ack_k - 1) begin @(posedge clk); #1; end
            BusAck = 1'b1; BusRData = brd;
            @(posedge clk); #1;
            BusAck = 1'b0; BusRData = 32'd0;
        end else begin
            n = 0;
            while (BusReq && n < 400) begin @(posedge clk); #1; n++; end
            chk("bus_release", 32'(BusReq), 32'd0);
        end
        MemWrite = 1'b0; MemRead = 1'b0; LSB = 1'b0;
        @(posedge clk); #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; LSB = 1'b0;
        DataAdr = 32'd0; WriteData = 32'd0; BusRData = 32'd0; BusAck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall",  32'(Stall),    32'd0);
        chk("rst_busreq", 32'(BusReq),   32'd0);
        chk("rst_buswe",  32'(BusWe),    32'd0);
        chk("rst_busadr", 32'(BusAdr),   32'd0);
        chk("rst_wdata",  BusWData,      32'd0);
        chk("rst_be",     32'(BusBe),    32'd0);
        chk("rst_rdata",  ReadData,      32'd0);
        chk("rst_err",    32'(BusErr),   32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Word load, ack in 2nd BUS cycle
        access(1'b0, 1'b1, 1'b0, 32'h64, 32'd0, 2, 32'h12345678,
               mk(30'h19, 1'b0, 4'hF, 32'd0, 32'h12345678, 1'b0, 2));
        // Word store, ack in 1st BUS cycle; ReadData held
        access(1'b1, 1'b0, 1'b0, 32'h64, 32'd7, 1, 32'd0,
               mk(30'h19, 1'b1, 4'hF, 32'd7, 32'h12345678, 1'b0, 1));
        // LDRB lane 2
        access(1'b0, 1'b1, 1'b1, 32'h66, 32'd0, 1, 32'hAABBCCDD,
               mk(30'h19, 1'b0, 4'b0100, 32'd0, 32'h000000BB, 1'b0, 1));
        // STRB 0x5A to 0x63
`ifdef DMEM_BYTE_STORE_EN
        access(1'b1, 1'b0, 1'b1, 32'h63, 32'h5A, 1, 32'd0,
               mk(30'h18, 1'b1, 4'b1000, 32'h5A5A5A5A, 32'h000000BB, 1'b0, 1));
`else
        access(1'b1, 1'b0, 1'b1, 32'h63, 32'h5A, 1, 32'd0,
               mk(30'h18, 1'b1, 4'hF, 32'h0000005A, 32'h000000BB, 1'b0, 1));
`endif
        // LDRB lane 0 and lane 3
        access(1'b0, 1'b1, 1'b1, 32'h100, 32'd0, 1, 32'hAABBCCDD,
               mk(30'h40, 1'b0, 4'b0001, 32'd0, 32'h000000DD, 1'b0, 1));
        access(1'b0, 1'b1, 1'b1, 32'h103, 32'd0, 2, 32'h11223344,
               mk(30'h40, 1'b0, 4'b1000, 32'd0, 32'h00000011, 1'b0, 2));
        // Unaligned word load: low address bits ignored
        access(1'b0, 1'b1, 1'b0, 32'h67, 32'd0, 1, 32'h89ABCDEF,
               mk(30'h19, 1'b0, 4'hF, 32'd0, 32'h89ABCDEF, 1'b0, 1));
        // Both strobes: write wins, read data on ack ignored
        access(1'b1, 1'b1, 1'b0, 32'h64, 32'hCAFEF00D, 2, 32'h55555555,
               mk(30'h19, 1'b1, 4'hF, 32'hCAFEF00D, 32'h89ABCDEF, 1'b0, 2));
        // Timeout: no ack
        access(1'b0, 1'b1, 1'b0, 32'h200, 32'd0, 0, 32'd0,
               mk(30'h80, 1'b0, 4'hF, 32'd0, 32'hDEADBEEF, 1'b1, 15));

        // Stray ack while idle
        BusAck = 1'b1; BusRData = 32'h01020304;
        @(posedge clk); #1;
        BusAck = 1'b0; BusRData = 32'd0;
        chk("stray_busreq", 32'(BusReq), 32'd0);
        chk("stray_stall",  32'(Stall),  32'd0);
        chk("stray_rdata",  ReadData,    32'hDEADBEEF);
        @(posedge clk); #1;

        // Next access after timeout: works, error stays sticky
        access(1'b0, 1'b1, 1'b0, 32'h64, 32'd0, 3, 32'h0BADF00D,
               mk(30'h19, 1'b0, 4'hF, 32'd0, 32'h0BADF00D, 1'b1, 3));

        // Reset in the middle of a BUS phase
        MemRead = 1'b1; DataAdr = 32'h64; LSB = 1'b0;
        @(posedge clk); #1;
        chk("mid_busreq_on", 32'(BusReq), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; MemRead = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busreq", 32'(BusReq), 32'd0);
        chk("mid_rst_err",    32'(BusErr), 32'd0);
        chk("mid_rst_rdata",  ReadData,    32'd0);
        chk("mid_rst_stall",  32'(Stall),  32'd0);
        reset = 1'b0;
        BusAck = 1'b1; BusRData = 32'hFFFFFFFF;
        @(posedge clk); #1;
        BusAck = 1'b0; BusRData = 32'd0;
        chk("post_rst_busreq", 32'(BusReq), 32'd0);
        chk("post_rst_stall",  32'(Stall),  32'd0);
        chk("post_rst_rdata",  ReadData,    32'd0);
        chk("post_rst_err",    32'(BusErr), 32'd0);
        @(posedge clk); #1;

        // Clean access after reset
        access(1'b0, 1'b1, 1'b0, 32'h64, 32'd0, 1, 32'h11223344,
               mk(30'h19, 1'b0, 4'hF, 32'd0, 32'h11223344, 1'b0, 1));

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
